pcm_frame_unpacker: RTL and testbench
=====================================

// Module: pcm_frame_unpacker
// PURPOSE
//   Sits between fifo_extmem and the two fo_sigma_delta_dac channels.
//   On each sample-rate tick it pulls one 4-byte stereo PCM frame from the FIFO, one byte per request.
//   It assembles two SAMPLE_BITS-wide words, optionally converts them from two's complement to
//   offset binary, and updates both DAC inputs atomically.
//   It also detects and counts underruns and late ticks, for flow-control diagnostics.
// PARAMETERS
//   SAMPLE_BITS  16  width of each channel word; fixed 2 bytes per channel.
//   FILL_BITS    20  width of the fifo_fill input (log2 of the FIFO size).
//   SIGNED_IN    0   1: input is two's complement; the block inverts the MSB to give offset binary.
//   CNT_BITS     16  width of the saturating diagnostic counters.
// PORTS
//   clk             in   1            system clock (sysclk domain).
//   reset           in   1            asynchronous, active-high reset.
//   sample_en       in   1            1-cycle tick at the sample rate.
//   fifo_fill       in   FILL_BITS    current FIFO occupancy, in bytes.
//   fifo_rd_en      out  1            1-cycle read request, one per byte.
//   fifo_rd_data    in   8            byte from the FIFO; valid only while fifo_completed=1.
//   fifo_completed  in   1            1-cycle pulse; the requested byte is present on fifo_rd_data.
//   left_out        out  SAMPLE_BITS  left DAC word.
//   right_out       out  SAMPLE_BITS  right DAC word.
//   sample_valid    out  1            1-cycle pulse in the cycle left_out/right_out change.
//   busy            out  1            high while a frame fetch is in progress.
//   underrun_cnt    out  CNT_BITS     saturating count of ticks with fill<4 while idle.
//   late_cnt        out  CNT_BITS     saturating count of ticks that arrive while busy.
// BEHAVIOUR
//   Reset values (asynchronous, take effect immediately):
//     state=IDLE; fifo_rd_en=0; busy=0; sample_valid=0.
//     left_out = right_out = MIDSCALE (1<<(SAMPLE_BITS-1)).
//     Both counters = 0. The byte index and staging registers are cleared.
//   Frame byte order: L_hi, L_lo, R_hi, R_lo.
//   FSM states: IDLE, REQ, WAIT, COMMIT.
//   - IDLE, sample_en=1, fill>=4 -> REQ. Byte index idx=0, busy=1.
//   - IDLE, sample_en=1, fill<4 -> stay in IDLE. Outputs hold their last value.
//     underrun_cnt increments (saturates at all-ones).
//   - REQ: assert fifo_rd_en for exactly one cycle -> WAIT.
//   - WAIT: on fifo_completed, store fifo_rd_data in staging[idx].
//     If idx==3 -> COMMIT; otherwise idx++ and -> REQ.
//     No timeout: WAIT may last arbitrarily long, since the SRAM latency is variable.
//   - COMMIT: load left_out and right_out in the same cycle.
//     If SIGNED_IN=1, the MSB of each word is inverted.
//     Pulse sample_valid, set busy=0 -> IDLE.
//   - A sample_en in REQ, WAIT or COMMIT is dropped, not queued. late_cnt increments (saturating).
//   Handshake rules:
//     - Never more than one outstanding request.
//     - fifo_rd_en is never high in the same cycle as fifo_completed.
//     - A fifo_completed seen outside WAIT is ignored.
//   Latency: tick -> sample_valid = 4*(1 + Lmem) + 2 cycles, where Lmem is the REQ-to-completed
//     delay in cycles.
//   The fill check is made once, in IDLE. The 4-byte frame is committed to the FIFO before reading
//     starts, so the FIFO cannot underflow mid-frame.
//   Reset mid-frame: the partial frame is discarded. Outputs return to MIDSCALE. The already-read
//     bytes are lost; the resulting frame misalignment is the host's responsibility, because the host
//     resyncs after reset.
//   Simultaneous events: a tick in the COMMIT cycle counts as late. A tick in IDLE in the same cycle
//     as reset deassertion is honoured.
// STRUCTURE
//   Shared header pcm_defs.vh holds:
//     - `PCM_FRAME_BYTES (4)
//     - `PCM_MIDSCALE(bits)
//     - the FSM state encodings, so top-level debug LEDs can decode the state.
//   One sub-module, sat_counter #(.BITS(CNT_BITS)) (inc, value, clk, reset), is instantiated twice:
//     once for underrun_cnt, once for late_cnt.
//   All other logic is inline.
// TESTING
//   1. Reset, then hold -> left_out=right_out=16'h8000, rd_en=0, both counters 0.
//   2. fill=8, tick, the FIFO model returns 12 34 56 78 (Lmem=3), SIGNED_IN=0
//      -> exactly 4 rd_en pulses; left=16'h1234, right=16'h5678; one sample_valid;
//         latency 4*4+2 = 18 cycles.
//   3. The same frame with SIGNED_IN=1 -> left=16'h9234, right=16'hD678.
//   4. fill=3, three ticks -> no rd_en; outputs unchanged; underrun_cnt=3.
//   5. Lmem=40, a second tick during the fetch -> late_cnt=1; one frame only; no extra rd_en.
//   6. Assert reset after the 2nd byte -> rd_en=0 at once; outputs=16'h8000.
//      A later full frame decodes correctly.
//      Also: counter saturation with CNT_BITS=2 and 5 underruns -> underrun_cnt=3.

Source files
------------

// File: rtl/pcm_frame_unpacker_pkg.sv
// Shared definitions for the PCM frame unpacker: frame size, FSM encoding, midscale helper.
// State encodings live here so debug logic elsewhere can decode the FSM.
package pcm_frame_unpacker_pkg;

    localparam int PCM_FRAME_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } pcm_state_e;

    function automatic logic [31:0] pcm_midscale(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/pcm_frame_unpacker_if.sv
// FIFO-side handshake, DAC outputs and diagnostics of the PCM frame unpacker.
// slave = the unpacker itself, master = the FIFO/tick environment driving it.
interface pcm_frame_unpacker_if #(
    parameter int SAMPLE_BITS = 16,
    parameter int FILL_BITS   = 20,
    parameter int CNT_BITS    = 16
);
    logic                   sample_en;
    logic [FILL_BITS-1:0]   fifo_fill;
    logic                   fifo_rd_en;
    logic [7:0]             fifo_rd_data;
    logic                   fifo_completed;
    logic [SAMPLE_BITS-1:0] left_out;
    logic [SAMPLE_BITS-1:0] right_out;
    logic                   sample_valid;
    logic                   busy;
    logic [CNT_BITS-1:0]    underrun_cnt;
    logic [CNT_BITS-1:0]    late_cnt;

    modport master (
        output sample_en, fifo_fill, fifo_rd_data, fifo_completed,
        input  fifo_rd_en, left_out, right_out, sample_valid, busy, underrun_cnt, late_cnt
    );

    modport slave (
        input  sample_en, fifo_fill, fifo_rd_data, fifo_completed,
        output fifo_rd_en, left_out, right_out, sample_valid, busy, underrun_cnt, late_cnt
    );
endinterface

// File: rtl/pcm_frame_unpacker_sat_counter.sv
// Saturating event counter; increments by one per cycle with inc high, sticks at all-ones.
// Single-cycle update, no backpressure.
module sat_counter #(
    parameter int BITS = 16
) (
    input  logic            inc,
    output logic [BITS-1:0] value,
    input  logic            clk,
    input  logic            reset
);
    logic [BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
endmodule

// File: rtl/pcm_frame_unpacker.sv
// Fetches one 4-byte stereo frame per sample tick (one outstanding byte request) and updates both DAC words atomically.
// Tick to sample_valid = 4*(1+Lmem)+2 cycles; ticks arriving mid-fetch are dropped and counted as late.
module pcm_frame_unpacker
    import pcm_frame_unpacker_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int FILL_BITS   = 20,
    parameter int SIGNED_IN   = 0,
    parameter int CNT_BITS    = 16
) (
    input logic               clk,
    input logic               reset,
    pcm_frame_unpacker_if.slave bus
);
    localparam logic [SAMPLE_BITS-1:0] MIDSCALE  = SAMPLE_BITS'(pcm_midscale(SAMPLE_BITS));
    localparam logic [15:0]            SIGN_FLIP = (SIGNED_IN != 0) ? 16'h8000 : 16'h0000;

    pcm_state_e                          state_q, state_d;
    logic [1:0]                          idx_q, idx_d;
    logic [PCM_FRAME_BYTES-1:0][7:0]     stg_q, stg_d;
    logic [SAMPLE_BITS-1:0]              left_q, left_d, right_q, right_d;
    logic                                valid_q, valid_d;
    logic                                fill_ok, underrun_inc, late_inc;
    logic [15:0]                         word_l, word_r;

    assign fill_ok      = bus.fifo_fill >= FILL_BITS'(PCM_FRAME_BYTES);
    assign underrun_inc = bus.sample_en && (state_q == ST_IDLE) && !fill_ok;
    assign late_inc     = bus.sample_en && (state_q != ST_IDLE);

    // Staging order on the wire is L_hi, L_lo, R_hi, R_lo.
    assign word_l = {stg_q[0], stg_q[1]} ^ SIGN_FLIP;
    assign word_r = {stg_q[2], stg_q[3]} ^ SIGN_FLIP;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stg_d   = stg_q;
        left_d  = left_q;
        right_d = right_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sample_en && fill_ok) begin
                    idx_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.fifo_completed) begin
                    stg_d[idx_q] = bus.fifo_rd_data;
                    if (idx_q == 2'(PCM_FRAME_BYTES - 1)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_COMMIT: begin
                left_d  = SAMPLE_BITS'(word_l);
                right_d = SAMPLE_BITS'(word_r);
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            stg_q   <= '0;
            left_q  <= MIDSCALE;
            right_q <= MIDSCALE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            left_q  <= left_d;
            right_q <= right_d;
            valid_q <= valid_d;
        end
    end

    assign bus.fifo_rd_en   = (state_q == ST_REQ);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.left_out     = left_q;
    assign bus.right_out    = right_q;
    assign bus.sample_valid = valid_q;

    sat_counter #(.BITS(CNT_BITS)) u_underrun_cnt (
        .inc   (underrun_inc),
        .value (bus.underrun_cnt),
        .clk   (clk),
        .reset (reset)
    );

    sat_counter #(.BITS(CNT_BITS)) u_late_cnt (
        .inc   (late_inc),
        .value (bus.late_cnt),
        .clk   (clk),
        .reset (reset)
    );
endmodule

// File: tb/tb_pcm_frame_unpacker.sv
// Bench: two unpackers share one FIFO model; dut0 unsigned/16-bit counters, dut1 signed-in/2-bit counters.
`timescale 1ns/1ps
module tb_pcm_frame_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [19:0] fifo_fill;
    logic [7:0]  fifo_rd_data;
    logic        fifo_completed;

    always #5 clk = ~clk;

    pcm_frame_unpacker_if #(.SAMPLE_BITS(16), .FILL_BITS(20), .CNT_BITS(16)) bus0 ();
    pcm_frame_unpacker_if #(.SAMPLE_BITS(16), .FILL_BITS(20), .CNT_BITS(2))  bus1 ();

    assign bus0.sample_en      = sample_en;
    assign bus0.fifo_fill      = fifo_fill;
    assign bus0.fifo_rd_data   = fifo_rd_data;
    assign bus0.fifo_completed = fifo_completed;
    assign bus1.sample_en      = sample_en;
    assign bus1.fifo_fill      = fifo_fill;
    assign bus1.fifo_rd_data   = fifo_rd_data;
    assign bus1.fifo_completed = fifo_completed;

    pcm_frame_unpacker #(.SAMPLE_BITS(16), .FILL_BITS(20), .SIGNED_IN(0), .CNT_BITS(16)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    pcm_frame_unpacker #(.SAMPLE_BITS(16), .FILL_BITS(20), .SIGNED_IN(1), .CNT_BITS(2)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          lat;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       e0, e1;
    logic [7:0] mem_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick_cyc = 0;
    int lmem = 3;
    int rd0 = 0, rd1 = 0, vld0 = 0, vld1 = 0, cmpl_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: answers each read request lmem cycles after the REQ cycle
    initial begin
        fifo_completed = 1'b0;
        fifo_rd_data   = 8'h00;
        forever begin
            @(negedge clk);
            if (bus0.fifo_rd_en) begin
                repeat (lmem) @(posedge clk);
                #1;
                if (mem_q.size() != 0) fifo_rd_data = mem_q.pop_front();
                else                   fifo_rd_data = 8'hEE;
                fifo_completed = 1'b1;
                cmpl_cnt++;
                @(posedge clk);
                #1 fifo_completed = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus0.fifo_rd_en) rd0++;
        if (bus1.fifo_rd_en) rd1++;
        if (bus0.sample_valid) begin
            vld0++;
            check_val("sb0_pending", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                check_val("left0", 32'(bus0.left_out), 32'(e0.l));
                check_val("right0", 32'(bus0.right_out), 32'(e0.r));
                if (e0.lat > 0) check_val("latency0", cyc - tick_cyc, e0.lat);
            end
        end
        if (bus1.sample_valid) begin
            vld1++;
            check_val("sb1_pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check_val("left1_signed", 32'(bus1.left_out), 32'(e1.l ^ 16'h8000));
                check_val("right1_signed", 32'(bus1.right_out), 32'(e1.r ^ 16'h8000));
            end
        end
    end

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int lat);
        exp_t e;
        mem_q.push_back(b0);
        mem_q.push_back(b1);
        mem_q.push_back(b2);
        mem_q.push_back(b3);
        e.l   = {b0, b1};
        e.r   = {b2, b3};
        e.lat = lat;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic tick(input bit record);
        @(posedge clk);
        #1;
        sample_en = 1'b1;
        if (record) tick_cyc = cyc;
        @(posedge clk);
        #1 sample_en = 1'b0;
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_val({tag, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb0, rb1, vb0, vb1, cb, n;
        logic [7:0] rb [4];
        reset     = 1'b1;
        sample_en = 1'b0;
        fifo_fill = 20'd0;

        // reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_left0", 32'(bus0.left_out), 32'h8000);
        check_val("rst_right0", 32'(bus0.right_out), 32'h8000);
        check_val("rst_left1", 32'(bus1.left_out), 32'h8000);
        check_val("rst_right1", 32'(bus1.right_out), 32'h8000);
        check_val("rst_rd_en", 32'(bus0.fifo_rd_en), 32'd0);
        check_val("rst_busy", 32'(bus0.busy), 32'd0);
        check_val("rst_valid", 32'(bus0.sample_valid), 32'd0);
        check_val("rst_underrun", 32'(bus0.underrun_cnt), 32'd0);
        check_val("rst_late", 32'(bus0.late_cnt), 32'd0);

        // basic frame, Lmem=3
        lmem = 3;
        fifo_fill = 20'd8;
        rb0 = rd0; rb1 = rd1; vb0 = vld0; vb1 = vld1;
        push_frame(8'h12, 8'h34, 8'h56, 8'h78, 4 * (1 + 3) + 2);
        tick(1'b1);
        wait_drained("frame1", 100);
        check_val("frame1_rd0", rd0 - rb0, 32'd4);
        check_val("frame1_rd1", rd1 - rb1, 32'd4);
        check_val("frame1_vld0", vld0 - vb0, 32'd1);
        check_val("frame1_vld1", vld1 - vb1, 32'd1);

        // underruns, then saturation of the 2-bit counter
        fifo_fill = 20'd3;
        rb0 = rd0;
        repeat (3) tick(1'b0);
        @(negedge clk);
        check_val("underrun_rd", rd0 - rb0, 32'd0);
        check_val("underrun_left0_hold", 32'(bus0.left_out), 32'h1234);
        check_val("underrun_left1_hold", 32'(bus1.left_out), 32'h9234);
        check_val("underrun_cnt0_3", 32'(bus0.underrun_cnt), 32'd3);
        check_val("underrun_cnt1_3", 32'(bus1.underrun_cnt), 32'd3);
        repeat (2) tick(1'b0);
        @(negedge clk);
        check_val("underrun_cnt0_5", 32'(bus0.underrun_cnt), 32'd5);
        check_val("underrun_cnt1_sat", 32'(bus1.underrun_cnt), 32'd3);
        check_val("underrun_late0", 32'(bus0.late_cnt), 32'd0);

        // slow memory with a late tick during the fetch
        lmem = 40;
        fifo_fill = 20'd8;
        rb0 = rd0; rb1 = rd1; vb0 = vld0; vb1 = vld1;
        push_frame(8'hAB, 8'hCD, 8'hEF, 8'h01, 4 * (1 + 40) + 2);
        tick(1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_val("slow_busy", 32'(bus0.busy), 32'd1);
        tick(1'b0);
        wait_drained("slow", 400);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("slow_rd0", rd0 - rb0, 32'd4);
        check_val("slow_rd1", rd1 - rb1, 32'd4);
        check_val("slow_vld0", vld0 - vb0, 32'd1);
        check_val("slow_late0", 32'(bus0.late_cnt), 32'd1);
        check_val("slow_late1", 32'(bus1.late_cnt), 32'd1);
        check_val("slow_idle", 32'(bus0.busy), 32'd0);

        // reset after the second byte of a frame
        lmem = 3;
        cb = cmpl_cnt;
        push_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
        tick(1'b1);
        n = 0;
        while (cmpl_cnt < cb + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("midrst_two_bytes", cmpl_cnt - cb, 32'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("midrst_rd_en0", 32'(bus0.fifo_rd_en), 32'd0);
        check_val("midrst_rd_en1", 32'(bus1.fifo_rd_en), 32'd0);
        check_val("midrst_left0", 32'(bus0.left_out), 32'h8000);
        check_val("midrst_right1", 32'(bus1.right_out), 32'h8000);
        check_val("midrst_busy", 32'(bus0.busy), 32'd0);
        mem_q.delete();
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);

        // tick in the same cycle as reset release is honoured
        push_frame(8'h5A, 8'hA5, 8'hC3, 8'h3C, 4 * (1 + 3) + 2);
        fifo_fill = 20'd8;
        rb0 = rd0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        sample_en = 1'b1;
        tick_cyc  = cyc;
        @(posedge clk);
        #1 sample_en = 1'b0;
        wait_drained("after_rst", 100);
        check_val("after_rst_rd0", rd0 - rb0, 32'd4);
        check_val("after_rst_late", 32'(bus0.late_cnt), 32'd0);
        check_val("after_rst_underrun", 32'(bus0.underrun_cnt), 32'd0);

        // a few random frames at random memory latency
        for (int k = 0; k < 4; k++) begin
            lmem = $urandom_range(1, 6);
            for (int b = 0; b < 4; b++) rb[b] = 8'($urandom);
            push_frame(rb[0], rb[1], rb[2], rb[3], 4 * (1 + lmem) + 2);
            tick(1'b1);
            wait_drained("rand", 100);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
